// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 responder backed by a 2**MEM_WORDS_LOG2 x 32-bit word array.
// Handles one transaction at a time, with single-beat and INCR bursts of 4-byte beats.
// Beat addresses wrap modulo the array depth.
// Optional macro MEM_SLAVE_DECERR_EN: when defined, beats outside the array window
// are decode errors. Write beats are dropped and the read data for such beats is zero.
module axi_mem_slave #(
    parameter int unsigned C_S_AXI_ID_WIDTH = 1,
    parameter int unsigned MEM_WORDS_LOG2   = 12,
    parameter logic [31:0] BASE_ADDR        = 32'h0000_0000
) (
    input  logic                        CCLK,
    input  logic                        CRST,
    input  logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_AWID,
    input  logic [31:0]                 S_AXI_AWADDR,
    input  logic [7:0]                  S_AXI_AWLEN,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [31:0]                 S_AXI_WDATA,
    input  logic [3:0]                  S_AXI_WSTRB,
    input  logic                        S_AXI_WLAST,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_BID,
    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_ARID,
    input  logic [31:0]                 S_AXI_ARADDR,
    input  logic [7:0]                  S_AXI_ARLEN,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_RID,
    output logic [31:0]                 S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RLAST,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY
);

    localparam int unsigned DEPTH = 1 << MEM_WORDS_LOG2;
`ifdef MEM_SLAVE_DECERR_EN
    localparam bit DECERR_EN = 1'b1;
`else
    localparam bit DECERR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WDATA = 3'd1,
        S_WRESP = 3'd2,
        S_RREAD = 3'd3,
        S_RDATA = 3'd4
    } state_t;

    state_t                      r_state;
    logic [31:0]                 r_mem [DEPTH];
    logic [C_S_AXI_ID_WIDTH-1:0] r_id;
    logic [29:0]                 r_off;      // start word offset from BASE_ADDR
    logic [7:0]                  r_len;
    logic [8:0]                  r_cnt;      // beats completed so far
    logic                        r_slverr;
    logic                        r_decerr;
    logic                        r_last_wr;  // last granted channel was write
    logic                        r_wready;
    logic                        r_bvalid;
    logic [1:0]                  r_bresp;
    logic                        r_rvalid;
    logic [31:0]                 r_rdata;
    logic [1:0]                  r_rresp;
    logic                        r_rlast;

    logic [31:0]                 w_aw_off;
    logic [31:0]                 w_ar_off;
    logic [29:0]                 w_beat_off;
    logic [MEM_WORDS_LOG2-1:0]   w_idx;
    logic                        w_oob;
    logic                        w_grant_w;
    logic                        w_grant_r;
    logic                        w_wbeat;
    logic                        w_wlast_exp;
    logic                        w_slverr_nx;
    logic                        w_decerr_nx;
    logic                        w_unused;

    assign w_aw_off    = S_AXI_AWADDR - BASE_ADDR;
    assign w_ar_off    = S_AXI_ARADDR - BASE_ADDR;
    assign w_beat_off  = r_off + 30'(r_cnt);
    assign w_idx       = w_beat_off[MEM_WORDS_LOG2-1:0];
    assign w_oob       = DECERR_EN && (w_beat_off[29:MEM_WORDS_LOG2] != '0);
    // When both channels request, the one not served last is granted.
    assign w_grant_w   = !CRST && (r_state == S_IDLE) && S_AXI_AWVALID &&
                         (!S_AXI_ARVALID || !r_last_wr);
    assign w_grant_r   = !CRST && (r_state == S_IDLE) && S_AXI_ARVALID && !w_grant_w;
    assign w_wbeat     = r_wready && S_AXI_WVALID;
    assign w_wlast_exp = (r_cnt == {1'b0, r_len});
    assign w_slverr_nx = r_slverr | (S_AXI_WLAST != w_wlast_exp);
    assign w_decerr_nx = r_decerr | w_oob;
    assign w_unused    = &{1'b0, w_aw_off[1:0], w_ar_off[1:0]};

    assign S_AXI_AWREADY = w_grant_w;
    assign S_AXI_ARREADY = w_grant_r;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BID     = r_id;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_RID     = r_id;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign S_AXI_RLAST   = r_rlast;
    assign S_AXI_RVALID  = r_rvalid;

    // Byte-enabled array write for each accepted in-range W beat; contents survive reset.
    always_ff @(posedge CCLK) begin
        if (!CRST && w_wbeat && !w_oob) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (S_AXI_WSTRB[b]) r_mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
    end

    // Transaction FSM that also drives the registered W, B and R channel outputs.
    always_ff @(posedge CCLK) begin
        if (CRST) begin
            r_state   <= S_IDLE;
            r_id      <= '0;
            r_off     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_slverr  <= 1'b0;
            r_decerr  <= 1'b0;
            r_last_wr <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
            r_rlast   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_w) begin
                        r_id      <= S_AXI_AWID;
                        r_off     <= w_aw_off[31:2];
                        r_len     <= S_AXI_AWLEN;
                        r_cnt     <= '0;
                        r_slverr  <= 1'b0;
                        r_decerr  <= 1'b0;
                        r_last_wr <= 1'b1;
                        r_wready  <= 1'b1;
                        r_state   <= S_WDATA;
                    end else if (w_grant_r) begin
                        r_id      <= S_AXI_ARID;
                        r_off     <= w_ar_off[31:2];
                        r_len     <= S_AXI_ARLEN;
                        r_cnt     <= '0;
                        r_last_wr <= 1'b0;
                        r_state   <= S_RREAD;
                    end
                end
                S_WDATA: begin
                    if (w_wbeat) begin
                        r_cnt    <= r_cnt + 9'd1;
                        r_slverr <= w_slverr_nx;
                        r_decerr <= w_decerr_nx;
                        // Burst length comes from AWLEN; WLAST only affects the response.
                        if (w_wlast_exp) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bresp  <= w_decerr_nx ? 2'b11 : (w_slverr_nx ? 2'b10 : 2'b00);
                            r_state  <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (S_AXI_BREADY) begin
                        r_bvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_RREAD: begin
                    r_rdata  <= w_oob ? '0 : r_mem[w_idx];
                    r_rresp  <= w_oob ? 2'b11 : 2'b00;
                    r_rlast  <= (r_cnt == {1'b0, r_len});
                    r_rvalid <= 1'b1;
                    r_state  <= S_RDATA;
                end
                S_RDATA: begin
                    if (S_AXI_RREADY) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        if (r_rlast) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 9'd1;
                            r_state <= S_RREAD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
